// File: rtl/morse_pkg.sv
// Shared Morse link definitions: frame length, letter table and receiver states.
// The Morse encoder is expected to move onto these same definitions.
package morse_pkg;

  localparam int MORSE_LEN = 12;

  typedef logic [MORSE_LEN-1:0] morse_code_t;
  typedef logic [2:0]           letter_t;

  // MSB first, 1 = tone on; dot = 1, dash = 111, one-unit gap, zero padded
  localparam morse_code_t MORSE_TABLE [8] = '{
    12'b101110000000,  // A
    12'b111010101000,  // B
    12'b111010111010,  // C
    12'b111010100000,  // D
    12'b100000000000,  // E
    12'b101011101000,  // F
    12'b111011101000,  // G
    12'b101010100000   // H
  };

  typedef enum logic [1:0] {IDLE, START, SAMPLE, DECODE} rx_state_t;

endpackage

// File: rtl/morse_code_match.sv
// Combinational lookup of a captured 12-unit frame against the letter table.
module morse_code_match
  import morse_pkg::*;
(
  input  morse_code_t code,
  output letter_t     letter,
  output logic        hit
);

  always_comb begin
    letter = '0;
    hit    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (code == MORSE_TABLE[i]) begin
        letter = letter_t'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// UART-style Morse receiver: rising-edge frame start, mid-unit sampling of a
// fixed 12-unit frame, then a one-cycle table decode into a letter code.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic    ClockIn,
  input  logic    Reset,
  input  logic    DotDashIn,
  output letter_t Letter,
  output logic    LetterValid,
  output logic    Error,
  output logic    Busy,
  output logic    SampleOut
);

  localparam int BIT   = CLOCK_FREQUENCY / 2;
  localparam int HALF  = CLOCK_FREQUENCY / 4;
  localparam int CNT_W = $clog2(BIT) + 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT - 1);

  logic             sync_p0;
  logic             din_s;
  logic             din_s_d;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  morse_code_t      shreg;
  letter_t          letter_q;
  letter_t          match_letter;
  logic             hit;
  logic             tick;

  // Stage p0..p2: two-flop synchroniser plus one delayed copy for edge detect
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      din_s   <= 1'b0;
      din_s_d <= 1'b0;
    end else begin
      sync_p0 <= DotDashIn;
      din_s   <= sync_p0;
      din_s_d <= din_s;
    end
  end

  assign tick = (cnt == '0);

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      letter_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_s && !din_s_d) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            // A start unit that is low at its midpoint was a glitch
            if (din_s) begin
              shreg <= {shreg[MORSE_LEN-2:0], 1'b1};
              idx   <= 4'd1;
              cnt   <= BIT_LOAD;
              state <= SAMPLE;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          if (tick) begin
            shreg <= {shreg[MORSE_LEN-2:0], din_s};
            idx   <= idx + 4'd1;
            cnt   <= BIT_LOAD;
            if (idx == 4'(MORSE_LEN - 1)) state <= DECODE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DECODE: begin
          if (hit) letter_q <= match_letter;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  morse_code_match u_match (
    .code   (shreg),
    .letter (match_letter),
    .hit    (hit)
  );

  // Result pulses are decoded from state so Letter changes in the same cycle
  assign SampleOut   = tick && (state == START || state == SAMPLE);
  assign LetterValid = (state == DECODE) && hit;
  assign Error       = (state == DECODE) && !hit;
  assign Busy        = (state != IDLE);
  assign Letter      = LetterValid ? match_letter : letter_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: builds a line/reset waveform, predicts every output
// cycle from the frame timing rules, then replays the waveform and compares.
module tb_morse_decoder;

  localparam int CF   = 8;
  localparam int BIT  = CF / 2;
  localparam int HALF = CF / 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [2:0] letter;
  logic       letter_valid;
  logic       error;
  logic       busy;
  logic       sample_out;

  morse_decoder #(.CLOCK_FREQUENCY(CF)) dut (
    .ClockIn     (clk),
    .Reset       (rst),
    .DotDashIn   (din),
    .Letter      (letter),
    .LetterValid (letter_valid),
    .Error       (error),
    .Busy        (busy),
    .SampleOut   (sample_out)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] CODES [8] = '{
    12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
    12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
  };

  bit         line_q[$];
  bit         rst_q[$];
  bit         ds[];
  bit         dsd[];
  bit         e_sample[];
  bit         e_valid[];
  bit         e_err[];
  bit         e_busy[];
  logic [2:0] e_letter[];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         n_cyc;
  int         exp_valid_cnt = 0;
  int         obs_valid_cnt = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic put(input bit v, input bit r, input int n);
    repeat (n) begin
      line_q.push_back(v);
      rst_q.push_back(r);
    end
  endtask

  // Drive a 12-unit frame, optionally cutting the last `cut` cycles short
  task automatic frame(input logic [11:0] code, input int cut);
    for (int i = 0; i < 12 * BIT - cut; i++) put(code[11 - i / BIT], 1'b0, 1);
  endtask

  // Frame interrupted by a one-cycle reset after `len` cycles, line then low
  task automatic frame_reset(input logic [11:0] code, input int len);
    for (int i = 0; i < len; i++) put(code[11 - i / BIT], 1'b0, 1);
    put(1'b0, 1'b1, 1);
  endtask

  // Cycle c shows state after posedge c; inputs set in cycle c act at posedge c+1
  task automatic build_model();
    bit         in_frame;
    int         t0;
    int         off;
    logic [11:0] bits;
    logic [2:0] cur;
    bit         hit;
    bit         s1 [];
    n_cyc = line_q.size();
    s1 = new[n_cyc];  ds = new[n_cyc];  dsd = new[n_cyc];
    e_sample = new[n_cyc]; e_valid = new[n_cyc]; e_err = new[n_cyc];
    e_busy = new[n_cyc]; e_letter = new[n_cyc];
    s1[0] = 0; ds[0] = 0; dsd[0] = 0;
    for (int c = 1; c < n_cyc; c++) begin
      s1[c]  = rst_q[c-1] ? 1'b0 : line_q[c-1];
      ds[c]  = rst_q[c-1] ? 1'b0 : s1[c-1];
      dsd[c] = rst_q[c-1] ? 1'b0 : ds[c-1];
    end
    in_frame = 0; t0 = 0; bits = '0; cur = '0;
    for (int c = 1; c < n_cyc; c++) begin
      e_sample[c] = 0; e_valid[c] = 0; e_err[c] = 0; e_busy[c] = 0;
      if (rst_q[c-1]) begin
        in_frame = 0;
        cur = '0;
      end else if (!in_frame) begin
        if (ds[c] && !dsd[c]) begin
          in_frame = 1;
          t0 = c;
        end
      end else begin
        e_busy[c] = 1;
        off = c - t0 - HALF;
        if (off >= 0 && off % BIT == 0 && off / BIT < 12) begin
          e_sample[c] = 1;
          bits[11 - off / BIT] = ds[c];
          if (off == 0 && !ds[c]) in_frame = 0;
        end else if (off == 11 * BIT + 1) begin
          hit = 0;
          for (int i = 0; i < 8; i++) begin
            if (bits == CODES[i]) begin
              hit = 1;
              cur = 3'(i);
            end
          end
          e_valid[c] = hit;
          e_err[c]   = !hit;
          if (hit) exp_valid_cnt++;
          in_frame = 0;
        end
      end
      e_letter[c] = cur;
    end
  endtask

  initial begin
    int r;
    logic [11:0] code;
    rst = 1'b1;
    din = 1'b0;

    put(1'b0, 1'b1, 3);
    put(1'b0, 1'b0, 6);
    frame(CODES[2], 0);                    put(1'b0, 1'b0, 4);  // C
    for (int i = 0; i < 8; i++) begin frame(CODES[i], 0); put(1'b0, 1'b0, 4); end
    put(1'b1, 1'b0, 1);                    put(1'b0, 1'b0, 10); // glitch
    frame(12'b111011101110, 0);            put(1'b0, 1'b0, 4);  // invalid
    frame_reset(CODES[7], 23);             put(1'b0, 1'b0, 20); // reset in sample 5 of H
    frame(CODES[0], 0);                    put(1'b0, 1'b0, 4);
    frame(CODES[4], 1);                    put(1'b1, 1'b0, 60); // E then held high
    put(1'b0, 1'b0, 6);
    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) frame(CODES[$urandom_range(0, 7)], 0);
      else if (r == 7) begin
        code = {1'b1, 10'($urandom), 1'b0};
        frame(code, 0);
      end else if (r == 8) put(1'b1, 1'b0, $urandom_range(1, 2));
      else frame_reset(CODES[$urandom_range(0, 7)], $urandom_range(1, 46));
      put(1'b0, 1'b0, $urandom_range(4, 9));
    end
    put(1'b0, 1'b0, 10);

    build_model();

    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      if (c >= 1) begin
        check("Letter",      {1'b0, letter},       {1'b0, e_letter[c]});
        check("LetterValid", {3'b0, letter_valid}, {3'b0, e_valid[c]});
        check("Error",       {3'b0, error},        {3'b0, e_err[c]});
        check("Busy",        {3'b0, busy},         {3'b0, e_busy[c]});
        check("SampleOut",   {3'b0, sample_out},   {3'b0, e_sample[c]});
        if (letter_valid === 1'b1) obs_valid_cnt++;
      end
      rst = rst_q[c];
      din = line_q[c];
    end
    n_assert++;
    assert (obs_valid_cnt == exp_valid_cnt) else begin
      n_fail++;
      $error("FAIL valid_count: observed %0d expected %0d", obs_valid_cnt, exp_valid_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
